io_handshake_sequencer: RTL and testbench

- Sequential stall controller for the user-I/O instructions: OUTPUT, INPUT and PAUSE.
- Sits between the control core's is_input/is_output flags, the board push-buttons, and the core's global enable.
- Replaces the raw "enable = button" path with synchronised, debounced press-and-release handshakes.
- Produces exactly one enable cycle per completed handshake, so the PC and register bank advance exactly once per user action.

---
 rtl/io_handshake_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_io_handshake_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_sequencer.sv
// Stalls the core on OUTPUT/INPUT/PAUSE until a debounced press-and-release of the
// selected button, then grants exactly one enable cycle. Define IO_TIMEOUT_EN for auto-fire.
module io_handshake_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       is_input,
    input  logic       is_output,
    input  logic       confirmation,
    input  logic       continue_button,
    output logic       enable,
    output logic       waiting,
    output logic       io_strobe,
    output logic [1:0] io_kind
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_FIRE
    } state_t;

    // Button index 0 = confirmation, 1 = continue_button.
    logic [1:0]                  btn_raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]                  synced;
    logic [1:0]                  deb_q, deb_d;
    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  rise_q, rise_d;
    logic [1:0]                  fall_q, fall_d;

    assign btn_raw = {continue_button, confirmation};
    assign synced  = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

    always_comb begin
        sync_d = sync_q;
        deb_d  = deb_q;
        cnt_d  = '0;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            sync_d[b] = {sync_q[b][SYNC_STAGES-2:0], btn_raw[b]};
            if (synced[b] != deb_q[b]) begin
                if (cnt_q[b] >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[b] = ~deb_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
            rise_d[b] = deb_d[b] & ~deb_q[b];
            fall_d[b] = ~deb_d[b] & deb_q[b];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    state_t     state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic       io_request;
    logic       sel_rise;
    logic       sel_fall;
    logic       timeout_hit;

    assign io_request = is_input | is_output;
    // PAUSE (kind 3) listens to continue_button, every other kind to confirmation.
    assign sel_rise   = (kind_q == 2'd3) ? rise_q[1] : rise_q[0];
    assign sel_fall   = (kind_q == 2'd3) ? fall_q[1] : fall_q[0];

`ifdef IO_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == S_WAIT_PRESS) begin
            tmo_d = (tmo_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // TIMEOUT_CYCLES has no effect in this build; the compare is constant false.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            kind_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        case (state_q)
            S_IDLE: begin
                if (io_request) begin
                    state_d = S_WAIT_PRESS;
                    kind_d  = {is_input, is_output};
                end
            end
            S_WAIT_PRESS: begin
                if (!io_request) begin
                    state_d = S_IDLE;
                    kind_d  = '0;
                end else if (sel_rise) begin
                    state_d = S_WAIT_RELEASE;
                end else if (timeout_hit) begin
                    state_d = S_FIRE;
                end
            end
            S_WAIT_RELEASE: begin
                if (!io_request) begin
                    state_d = S_IDLE;
                    kind_d  = '0;
                end else if (sel_fall) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                state_d = S_IDLE;
                kind_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                kind_d  = '0;
            end
        endcase
    end

    always_comb begin
        enable    = 1'b0;
        waiting   = 1'b0;
        io_strobe = 1'b0;
        case (state_q)
            S_IDLE:       enable = reset & ~io_request;
            S_WAIT_PRESS: waiting = 1'b1;
            S_FIRE: begin
                enable    = 1'b1;
                io_strobe = 1'b1;
            end
            default: ;
        endcase
    end

    assign io_kind = kind_q;

endmodule

// File: tb/tb_io_handshake_sequencer.sv
// Bench for io_handshake_sequencer: a cycle-level handshake model checked every cycle,
// plus hand-computed latencies for each directed scenario.
module tb_io_handshake_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int TMO  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       is_input = 1'b0;
    logic       is_output = 1'b0;
    logic       confirmation = 1'b0;
    logic       continue_button = 1'b0;
    logic       enable;
    logic       waiting;
    logic       io_strobe;
    logic [1:0] io_kind;

    io_handshake_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .is_input       (is_input),
        .is_output      (is_output),
        .confirmation   (confirmation),
        .continue_button(continue_button),
        .enable         (enable),
        .waiting        (waiting),
        .io_strobe      (io_strobe),
        .io_kind        (io_kind)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_strobe = 0;
    int strobe_cyc = 0;
    int cnt_en = 0;
    int cnt_wait = 0;
    int t0 = 0;
    int n0 = 0;
    bit strobe_seen = 0;
    logic [1:0] strobe_kind = '0;
    logic s_en, s_wait, s_str;
    logic [1:0] s_kind;

    // Model: 0 idle, 1 waiting for press, 2 waiting for release, 3 firing.
    int       m_state;
    int       m_wp;
    bit [1:0] m_kind;
    bit       m_sync[2][SYNC];
    bit       m_win[2][DEB];
    bit       m_deb[2];
    bit       m_rise[2];
    bit       m_fall[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_kind  = '0;
        m_wp    = 0;
        for (int b = 0; b < 2; b++) begin
            m_deb[b]  = 1'b0;
            m_rise[b] = 1'b0;
            m_fall[b] = 1'b0;
            for (int i = 0; i < SYNC; i++) m_sync[b][i] = 1'b0;
            for (int i = 0; i < DEB; i++) m_win[b][i] = 1'b0;
        end
    endtask

    task automatic model_update();
        bit req;
        bit r;
        bit f;
        bit all_diff;
        bit raw;
        int sel;
        req = is_input | is_output;
        sel = (m_kind == 2'd3) ? 1 : 0;
        r   = m_rise[sel];
        f   = m_fall[sel];
        case (m_state)
            0: if (req) begin
                m_kind  = {is_input, is_output};
                m_state = 1;
                m_wp    = 0;
            end
            1: begin
                m_wp++;
                if (!req) begin
                    m_state = 0;
                    m_kind  = '0;
                end else if (r) begin
                    m_state = 2;
`ifdef IO_TIMEOUT_EN
                end else if (m_wp >= TMO) begin
                    m_state = 3;
`endif
                end
            end
            2: begin
                if (!req) begin
                    m_state = 0;
                    m_kind  = '0;
                end else if (f) begin
                    m_state = 3;
                end
            end
            default: begin
                m_state = 0;
                m_kind  = '0;
            end
        endcase
        // A level flips once the last DEB synchronised samples all disagree with it.
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? confirmation : continue_button;
            for (int i = DEB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
            m_win[b][0] = m_sync[b][SYNC-1];
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_win[b][i] == m_deb[b]) all_diff = 1'b0;
            m_rise[b] = 1'b0;
            m_fall[b] = 1'b0;
            if (all_diff) begin
                m_deb[b] = ~m_deb[b];
                if (m_deb[b]) m_rise[b] = 1'b1;
                else          m_fall[b] = 1'b1;
            end
            for (int i = SYNC - 1; i > 0; i--) m_sync[b][i] = m_sync[b][i-1];
            m_sync[b][0] = raw;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic step();
        logic       req;
        logic       e_en, e_wait, e_str;
        logic [1:0] e_kind;
        req = is_input | is_output;
        if (!reset) begin
            e_en = 1'b0; e_wait = 1'b0; e_str = 1'b0; e_kind = '0;
        end else begin
            e_en   = (m_state == 0 && !req) || m_state == 3;
            e_wait = (m_state == 1);
            e_str  = (m_state == 3);
            e_kind = m_kind;
        end
        #1;
        check("enable", enable, e_en);
        check("waiting", waiting, e_wait);
        check("io_strobe", io_strobe, e_str);
        check("io_kind", io_kind, e_kind);
        s_en = enable; s_wait = waiting; s_str = io_strobe; s_kind = io_kind;
        if (io_strobe === 1'b1) begin
            strobe_seen = 1'b1;
            strobe_cyc  = cyc;
            strobe_kind = io_kind;
            n_strobe++;
        end
        if (enable === 1'b1) cnt_en++;
        if (waiting === 1'b1) cnt_wait++;
        @(posedge clock);
        if (reset) model_update();
        @(negedge clock);
        cyc++;
    endtask

    task automatic wait_strobe(input int max, input string name);
        strobe_seen = 1'b0;
        for (int i = 0; i < max && !strobe_seen; i++) step();
        check(name, strobe_seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clock);
        step();
        check("reset_enable", s_en, 0);
        check("reset_kind", s_kind, 0);
        reset = 1'b1;
        step();
        check("idle_enable", s_en, 1);

        // Single OUTPUT with a 10-cycle confirmation press.
        is_output = 1'b1; confirmation = 1'b1;
        t0 = cyc; cnt_en = 0; cnt_wait = 0;
        repeat (10) step();
        confirmation = 1'b0;
        wait_strobe(40, "t1_fire");
        check("t1_fire_cycle", strobe_cyc - t0, 17);
        check("t1_kind", strobe_kind, 1);
        check("t1_wait_cycles", cnt_wait, 6);
        check("t1_enable_cycles", cnt_en, 1);

`ifndef IO_TIMEOUT_EN
        // Back-to-back INPUT, then 3-cycle glitches on confirmation.
        is_output = 1'b0; is_input = 1'b1;
        step(); step();
        check("t2_kind", s_kind, 2);
        n0 = n_strobe;
        repeat (3) begin
            confirmation = 1'b1;
            repeat (3) step();
            confirmation = 1'b0;
            repeat (4) step();
        end
        check("t2_no_fire", n_strobe - n0, 0);
        check("t2_waiting", s_wait, 1);
        check("t2_stalled", s_en, 0);
        is_input = 1'b0;
        step(); step();
        check("t2_abort_enable", s_en, 1);
        check("t2_abort_kind", s_kind, 0);

        // PAUSE ignores confirmation and fires on continue_button.
        is_input = 1'b1; is_output = 1'b1;
        step(); step();
        n0 = n_strobe;
        confirmation = 1'b1;
        repeat (8) step();
        confirmation = 1'b0;
        repeat (12) step();
        check("t3_confirm_ignored", n_strobe - n0, 0);
        check("t3_waiting", s_wait, 1);
        t0 = cyc;
        continue_button = 1'b1;
        repeat (8) step();
        continue_button = 1'b0;
        wait_strobe(40, "t3_fire");
        check("t3_fire_cycle", strobe_cyc - t0, 15);
        check("t3_kind", strobe_kind, 3);
        is_input = 1'b0; is_output = 1'b0;
        step(); step();

        // Button already held when INPUT arrives.
        confirmation = 1'b1;
        repeat (8) step();
        is_input = 1'b1;
        n0 = n_strobe;
        repeat (10) step();
        check("t4_held_no_fire", n_strobe - n0, 0);
        check("t4_held_waiting", s_wait, 1);
        confirmation = 1'b0;
        repeat (10) step();
        check("t4_release_waiting", s_wait, 1);
        check("t4_release_no_fire", n_strobe - n0, 0);
        t0 = cyc;
        confirmation = 1'b1;
        repeat (8) step();
        confirmation = 1'b0;
        wait_strobe(40, "t4_fire");
        check("t4_fire_cycle", strobe_cyc - t0, 15);
        check("t4_kind", strobe_kind, 2);
        is_input = 1'b0;
        step(); step();
`else
        is_output = 1'b0;
        step(); step();
`endif

        // Asynchronous reset while waiting for release.
        is_output = 1'b1; confirmation = 1'b1;
        repeat (8) step();
        check("t5_in_release_wait", s_wait, 0);
        check("t5_in_release_en", s_en, 0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("t5_async_enable", enable, 0);
        check("t5_async_waiting", waiting, 0);
        check("t5_async_strobe", io_strobe, 0);
        check("t5_async_kind", io_kind, 0);
        @(negedge clock);
        is_output = 1'b0; confirmation = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("t5_release_enable", s_en, 1);
        check("t5_release_kind", s_kind, 0);

`ifdef IO_TIMEOUT_EN
        is_output = 1'b1;
        t0 = cyc;
        wait_strobe(30, "t6_timeout_fire");
        check("t6_fire_cycle", strobe_cyc - t0, 9);
        check("t6_kind", strobe_kind, 1);
`else
        is_output = 1'b1;
        n0 = n_strobe;
        repeat (100) step();
        check("t6_no_timeout", n_strobe - n0, 0);
        check("t6_waiting", s_wait, 1);
`endif
        is_output = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
